// File: rtl/pll_sup_pkg.sv
// Shared state encoding and default timing constants for the PLL lock supervisor.
// Latency/backpressure: none, this file holds definitions only.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchronizer for slow level signals (lock/status) crossing into a clock domain.
// Latency: 2 cycles; no backpressure, the input is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, gates downstream reset and latches repeated lock failures.
// Latency: lock-to-decision 2 cycles, outputs registered; no backpressure.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    input  logic       fault_clr,
    output logic       pll_reset,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [7:0] loss_cnt
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

    pll_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [7:0]         loss_nxt;
    logic               lock_s;
    logic               retry_last;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (lock),
        .q   (lock_s)
    );

    // The timeout that would exhaust the retry budget goes to FAULT instead of counting
    assign retry_last = (int'(retry_cnt) + 1) == MAX_RETRIES;

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        case (state)
            RST_PLL: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_last) begin
                        state_nxt = FAULT;
                    end else begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = RST_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = RST_PLL;
                    if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nxt = RST_PLL;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = RST_PLL;
        endcase
    end

    // One cycle counter serves every timed state and restarts on each transition
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state inside {RST_PLL, WAIT_LOCK, STABLE}) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= RST_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
            pll_reset <= (state_nxt == RST_PLL);
            sys_ready <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a cycle-level reference model and literal checkpoints.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       clkin = 1'b0;
    logic       reset;
    logic       lock;
    logic       fault_clr;
    logic       pll_reset;
    logic       sys_ready;
    logic       fault;
    logic [2:0] state_o;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;
    int k;

    // Reference model: state as plain ints, time spent in state, two-deep lock history
    int m_state, m_age, m_retry, m_loss, m_ns;
    bit m_s1, m_s2, m_ls;

    // Hand-derived state sequences, one entry per cycle after reset release
    int t1[15] = '{0,0,0,0,1,2,2,2,2,2,2,2,2,3,3};
    int t2[22] = '{0,0,0,0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,2,2,3,3};

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
        .fault_clr (fault_clr),
        .pll_reset (pll_reset),
        .sys_ready (sys_ready),
        .fault     (fault),
        .state_o   (state_o),
        .loss_cnt  (loss_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            m_state = 0; m_age = 0; m_retry = 0; m_loss = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            m_ls = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            m_ns = m_state;
            case (m_state)
                0: if (m_age + 1 == RST_CYCLES) m_ns = 1;
                1: begin
                    if (m_ls) m_ns = 2;
                    else if (m_age + 1 == LOCK_TIMEOUT) begin
                        m_retry++;
                        m_ns = (m_retry == MAX_RETRIES) ? 4 : 0;
                    end
                end
                2: begin
                    if (!m_ls) m_ns = 1;
                    else if (m_age + 1 == STABLE_CYCLES) begin
                        m_ns = 3;
                        m_retry = 0;
                    end
                end
                3: if (!m_ls) begin
                    m_ns = 0;
                    m_loss = (m_loss == 255) ? 255 : m_loss + 1;
                end
                4: if (fault_clr) begin
                    m_ns = 0;
                    m_retry = 0;
                end
                default: m_ns = 0;
            endcase
            m_age = (m_ns == m_state) ? m_age + 1 : 0;
            m_state = m_ns;
        end
    end

    always @(negedge clkin) begin
        if (started) begin
            chk("model_state", int'(state_o), m_state);
            chk("model_pll_reset", int'(pll_reset), int'(m_state == 0));
            chk("model_sys_ready", int'(sys_ready), int'(m_state == 3));
            chk("model_fault", int'(fault), int'(m_state == 4));
            chk("model_loss_cnt", int'(loss_cnt), m_loss);
        end
    end

    task automatic cyc();
        @(posedge clkin);
        #1;
        k++;
    endtask

    task automatic do_reset(input logic lk);
        reset = 1'b1;
        lock = lk;
        fault_clr = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        k = 0;
        started = 1'b1;
    endtask

    task automatic wait_state(input int s, input int lim, input string name);
        int n;
        n = 0;
        while (int'(state_o) != s && n < lim) begin
            cyc();
            n++;
        end
        chk(name, int'(state_o), s);
    endtask

    initial begin
        int exp_s;
        reset = 1'b1;
        lock = 1'b0;
        fault_clr = 1'b0;
        k = 0;

        // Lock high throughout: 4-cycle pll_reset pulse, STABLE, RUN after 8 stable cycles
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) cyc();
            chk("t1_state", int'(state_o), t1[i]);
            chk("t1_pll_reset", int'(pll_reset), int'(t1[i] == 0));
            chk("t1_sys_ready", int'(sys_ready), int'(t1[i] == 3));
        end

        // One-cycle lock drop at stable count 5 bounces to WAIT_LOCK and restarts the count
        do_reset(1'b1);
        for (int i = 0; i < 22; i++) begin
            if (i > 0) cyc();
            chk("t2_state", int'(state_o), t2[i]);
            chk("t2_sys_ready", int'(sys_ready), int'(t2[i] == 3));
            if (i == 8) lock = 1'b0;
            if (i == 9) lock = 1'b1;
        end

        // fault_clr outside FAULT has no effect
        for (int i = 0; i < 6; i++) begin
            fault_clr = ~fault_clr;
            cyc();
            chk("clr_in_run_state", int'(state_o), 3);
        end
        fault_clr = 1'b0;

        // Lock loss in RUN: sys_ready falls on the third edge
        lock = 1'b0;
        cyc();
        cyc();
        chk("loss_ready_still_high", int'(sys_ready), 1);
        cyc();
        chk("loss_ready_low", int'(sys_ready), 0);
        chk("loss_pll_reset", int'(pll_reset), 1);
        chk("loss_cnt_one", int'(loss_cnt), 1);
        lock = 1'b1;
        for (int i = 1; i < 300; i++) begin
            wait_state(3, 40, "relock_run");
            lock = 1'b0;
            repeat (3) cyc();
            chk("loss_to_rst", int'(state_o), 0);
            lock = 1'b1;
        end
        chk("loss_cnt_saturated", int'(loss_cnt), 255);
        wait_state(3, 40, "relock_before_reset");

        // Asynchronous reset in RUN takes effect before the next edge
        reset = 1'b1;
        #1;
        chk("arst_pll_reset", int'(pll_reset), 1);
        chk("arst_sys_ready", int'(sys_ready), 0);
        chk("arst_loss_cnt", int'(loss_cnt), 0);
        chk("arst_state", int'(state_o), 0);

        // Lock never arrives: two timed-out attempts, then FAULT
        do_reset(1'b0);
        for (int i = 0; i < 52; i++) begin
            if (i > 0) cyc();
            exp_s = (i < 4) ? 0 : (i < 24) ? 1 : (i < 28) ? 0 : (i < 48) ? 1 : 4;
            chk("t6_state", int'(state_o), exp_s);
            chk("t6_pll_reset", int'(pll_reset), int'(exp_s == 0));
            chk("t6_fault", int'(fault), int'(exp_s == 4));
        end
        lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("fault_hold_state", int'(state_o), 4);
            chk("fault_hold_pll_reset", int'(pll_reset), 0);
        end
        lock = 1'b0;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("clr_state", int'(state_o), 0);
        chk("clr_fault", int'(fault), 0);
        for (int i = 0; i < 4; i++) begin
            chk("clr_pll_reset_pulse", int'(pll_reset), 1);
            cyc();
        end
        chk("clr_pulse_end", int'(pll_reset), 0);
        chk("clr_wait_lock", int'(state_o), 1);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time exceeded");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
